// File: rtl/regfile_exec_unit_if.sv
// Issue, preload, result and debug signals of the register-file execute unit.
// The master side is the instruction source; the slave side is the unit itself.
interface regfile_exec_unit_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    // Handshake: an instruction transfers on the rising edge where issue_valid
    // and issue_ready are both high; the master holds it stable until then.
    logic              issue_valid;
    logic              issue_ready;
    logic [ADDR_W-1:0] read_reg1;
    logic [ADDR_W-1:0] read_reg2;
    logic [ADDR_W-1:0] write_reg;
    logic [5:0]        alu_op;
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] result;
    logic              result_valid;
    logic              zero;
    logic              overflow;
    logic              illegal_op;
    logic              busy;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_data;

    modport master (
        output issue_valid, read_reg1, read_reg2, write_reg, alu_op,
        output load_en, load_addr, load_data, dbg_addr,
        input  issue_ready, result, result_valid, zero, overflow, illegal_op,
        input  busy, dbg_data
    );

    modport slave (
        input  issue_valid, read_reg1, read_reg2, write_reg, alu_op,
        input  load_en, load_addr, load_data, dbg_addr,
        output issue_ready, result, result_valid, zero, overflow, illegal_op,
        output busy, dbg_data
    );
endinterface

// File: rtl/regfile_exec_unit.sv
// Multi-cycle execute stage: 32-entry register file, ALU and writeback,
// sequenced IDLE -> READ -> EXEC -> WB with one instruction in flight.
module regfile_exec_unit #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    regfile_exec_unit_if.slave  bus,
    output logic [1:0]          o_state
);
    localparam int NREGS = 1 << ADDR_W;
    localparam int MSB   = DATA_W - 1;

    localparam logic [5:0] OP_AND = 6'b000000;
    localparam logic [5:0] OP_OR  = 6'b000001;
    localparam logic [5:0] OP_ADD = 6'b000010;
    localparam logic [5:0] OP_SUB = 6'b000110;
    localparam logic [5:0] OP_SLT = 6'b000111;
    localparam logic [5:0] OP_NOR = 6'b001100;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_regs [NREGS];
    logic [ADDR_W-1:0] r_rs, r_rt, r_rd;
    logic [5:0]        r_op;
    logic [DATA_W-1:0] r_a, r_b;
    logic [DATA_W-1:0] r_result;
    logic              r_result_valid, r_zero, r_ovf, r_ill;

    logic [DATA_W-1:0] w_sum, w_diff, w_res;
    logic              w_ovf, w_ill;

    always_comb begin
        w_sum  = r_a + r_b;
        w_diff = r_a - r_b;
        w_res  = '0;
        w_ovf  = 1'b0;
        w_ill  = 1'b0;
        case (r_op)
            OP_AND: w_res = r_a & r_b;
            OP_OR:  w_res = r_a | r_b;
            OP_ADD: begin
                w_res = w_sum;
                w_ovf = (r_a[MSB] == r_b[MSB]) && (w_sum[MSB] != r_a[MSB]);
            end
            OP_SUB: begin
                w_res = w_diff;
                w_ovf = (r_a[MSB] != r_b[MSB]) && (w_diff[MSB] != r_a[MSB]);
            end
            OP_SLT: w_res = {{(DATA_W-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
            OP_NOR: w_res = ~(r_a | r_b);
            default: w_ill = 1'b1;
        endcase
    end

    // Register 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= S_IDLE;
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
            r_rs           <= '0;
            r_rt           <= '0;
            r_rd           <= '0;
            r_op           <= '0;
            r_a            <= '0;
            r_b            <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_zero         <= 1'b0;
            r_ovf          <= 1'b0;
            r_ill          <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.load_en && bus.load_addr != '0)
                        r_regs[bus.load_addr] <= bus.load_data;
                    if (bus.issue_valid) begin
                        r_rs    <= bus.read_reg1;
                        r_rt    <= bus.read_reg2;
                        r_rd    <= bus.write_reg;
                        r_op    <= bus.alu_op;
                        r_state <= S_READ;
                    end
                end
                S_READ: begin
                    r_a     <= r_regs[r_rs];
                    r_b     <= r_regs[r_rt];
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    r_result       <= w_res;
                    r_zero         <= (w_res == '0);
                    r_ovf          <= w_ovf;
                    r_ill          <= w_ill;
                    r_result_valid <= 1'b1;
                    r_state        <= S_WB;
                end
                S_WB: begin
                    r_result_valid <= 1'b0;
                    if (!r_ill && r_rd != '0)
                        r_regs[r_rd] <= r_result;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.issue_ready  = (r_state == S_IDLE);
    assign bus.busy         = (r_state != S_IDLE);
    assign bus.result       = r_result;
    assign bus.result_valid = r_result_valid;
    assign bus.zero         = r_zero;
    assign bus.overflow     = r_ovf;
    assign bus.illegal_op   = r_ill;
    assign bus.dbg_data     = r_regs[bus.dbg_addr];
    assign o_state          = r_state;
endmodule
